pipelined_mux_tree: RTL and testbench

//  Parametrised N:1 multiplexer (N = 2**SEL_W) of DATA_W-bit words, built as a binary tree of 2:1 levels.

---
 rtl/pipelined_mux_tree_pkg.sv | 21 ++
 rtl/pipelined_mux_tree_level.sv | 77 +++++++
 rtl/pipelined_mux_tree.sv | 81 ++++++++
 tb/tb_pipelined_mux_tree.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_mux_tree_pkg.sv
// Shared constants and helpers for the pipelined mux tree.
// Latency of a tree is the number of registered levels among the SEL_W real ones.
package pipelined_mux_tree_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefSelW  = 4;
  localparam logic [31:0] DefPipeMask = 32'h0000_000F;

  // Mask bits at or above sel_w do not correspond to a level and are ignored.
  function automatic int unsigned pipe_latency(input int unsigned sel_w, input logic [31:0] mask);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (k < sel_w && mask[k]) begin
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/pipelined_mux_tree_level.sv
// One level of a binary mux tree: NODES 2:1 muxes steered by select bit LVL, with an optional
// valid/data/select register whose load enable also drives the upstream ready.
module pipelined_mux_tree_level
  import pipelined_mux_tree_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned NODES  = 1,
  parameter int unsigned SEL_W  = DefSelW,
  parameter int unsigned LVL    = 0,
  parameter bit          REG    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*NODES*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NODES*DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [NODES*DATA_W-1:0] w_mux;
  logic [SEL_W-1:0]        w_sel_nxt;

  always_comb begin
    w_mux = '0;
    for (int unsigned i = 0; i < NODES; i++) begin
      w_mux[i*DATA_W +: DATA_W] = in_sel[LVL] ? in_data[(2*i+1)*DATA_W +: DATA_W]
                                              : in_data[(2*i)*DATA_W +: DATA_W];
    end
    // Consumed select bits are zeroed so their register bits reduce to constants.
    w_sel_nxt = '0;
    for (int unsigned b = 0; b < SEL_W; b++) begin
      if (b > LVL) begin
        w_sel_nxt[b] = in_sel[b];
      end
    end
  end

  if (REG) begin : g_reg
    logic                    r_valid;
    logic [NODES*DATA_W-1:0] r_data;
    logic [SEL_W-1:0]        r_sel;
    logic                    w_load;

    // An empty stage loads regardless of downstream, so bubbles collapse during a stall.
    assign w_load = ~r_valid | out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_sel   <= '0;
      end else if (w_load) begin
        r_valid <= in_valid;
        r_data  <= w_mux;
        r_sel   <= w_sel_nxt;
      end
    end

    assign in_ready  = w_load;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;
  end else begin : g_comb
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = w_mux;
    assign out_sel   = w_sel_nxt;
  end

endmodule

// File: rtl/pipelined_mux_tree.sv
// N:1 mux (N = 2**SEL_W) built as a chain of tree levels; PIPE_MASK[k] registers level k.
// Ready ripples combinationally from out_ready back to in_ready.
module pipelined_mux_tree
  import pipelined_mux_tree_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned SEL_W     = DefSelW,
  parameter logic [31:0] PIPE_MASK = DefPipeMask
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [(2**SEL_W)*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]               in_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int unsigned N = 2 ** SEL_W;

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int unsigned Nodes = N >> (k + 1);
    localparam bit          Reg   = PIPE_MASK[k];

    logic [2*Nodes*DATA_W-1:0] w_data_in;
    logic [SEL_W-1:0]          w_sel_in;
    logic                      w_valid_in;
    logic                      w_ready_in;
    logic [Nodes*DATA_W-1:0]   w_data;
    logic [SEL_W-1:0]          w_sel;
    logic                      w_valid;
    logic                      w_ready_out;

    if (k == 0) begin : g_first
      // Inputs offered during reset must never enter the pipe.
      assign w_data_in  = in_data;
      assign w_sel_in   = in_sel;
      assign w_valid_in = in_valid & ~rst;
    end else begin : g_next
      assign w_data_in  = g_lvl[k-1].w_data;
      assign w_sel_in   = g_lvl[k-1].w_sel;
      assign w_valid_in = g_lvl[k-1].w_valid;
    end

    if (k == SEL_W - 1) begin : g_last
      assign w_ready_out = out_ready;
    end else begin : g_mid
      assign w_ready_out = g_lvl[k+1].w_ready_in;
    end

    pipelined_mux_tree_level #(
      .DATA_W (DATA_W),
      .NODES  (Nodes),
      .SEL_W  (SEL_W),
      .LVL    (k),
      .REG    (Reg)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_data   (w_data_in),
      .in_sel    (w_sel_in),
      .in_valid  (w_valid_in),
      .in_ready  (w_ready_in),
      .out_data  (w_data),
      .out_sel   (w_sel),
      .out_valid (w_valid),
      .out_ready (w_ready_out)
    );
  end

  assign in_ready  = g_lvl[0].w_ready_in & ~rst;
  assign out_data  = g_lvl[SEL_W-1].w_data;
  assign out_valid = g_lvl[SEL_W-1].w_valid;

  // Every select bit has been consumed by the root level.
  logic w_unused_sel;
  assign w_unused_sel = ^g_lvl[SEL_W-1].w_sel;

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Bench for pipelined_mux_tree: scoreboard model on the default 4-stage tree, directed latency
// check on a 2-stage tree, random vectors on a purely combinational tree.
module tb_pipelined_mux_tree;
  import pipelined_mux_tree_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned N  = 16;
  localparam int unsigned L  = 4;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] m_in_data;
  logic [SW-1:0]   m_in_sel;
  logic            m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [DW-1:0]   m_out_data;

  logic [N*DW-1:0] b_in_data;
  logic [SW-1:0]   b_in_sel;
  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0]   b_out_data;

  logic [7:0]      c_in_data;
  logic [2:0]      c_in_sel;
  logic            c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [0:0]      c_out_data;

  pipelined_mux_tree #(.DATA_W(DW), .SEL_W(SW), .PIPE_MASK(32'hF)) u_dut_m (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_sel(m_in_sel), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(m_out_ready)
  );

  pipelined_mux_tree #(.DATA_W(DW), .SEL_W(SW), .PIPE_MASK(32'b0101)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  pipelined_mux_tree #(.DATA_W(1), .SEL_W(3), .PIPE_MASK(32'h0)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q_data[$];
  int unsigned q_acc[$];
  int unsigned cyc = 0;
  bit          accepted;
  bit          chk_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: words in flight form a FIFO; the head is visible once L cycles old, and any empty
  // stage (fewer than L words held) or a ready consumer lets a new word in.
  task automatic tick();
    bit         exp_r;
    bit         exp_v;
    logic [7:0] word;
    @(negedge clk);
    exp_r = !rst && (m_out_ready || q_data.size() < L);
    exp_v = (q_data.size() > 0) && (cyc - q_acc[0] >= L);
    check("in_ready", 32'(m_in_ready), 32'(exp_r));
    check("out_valid", 32'(m_out_valid), 32'(exp_v));
    if (exp_v) check("out_data", 32'(m_out_data), 32'(q_data[0]));
    if (chk_zero) begin
      check("out_data_after_reset", 32'(m_out_data), 32'h0);
      chk_zero = 1'b0;
    end
    word = m_in_data[m_in_sel*DW +: DW];
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      q_data.delete();
      q_acc.delete();
    end else begin
      if (exp_v && m_out_ready) begin
        void'(q_data.pop_front());
        void'(q_acc.pop_front());
      end
      if (m_in_valid && exp_r) begin
        q_data.push_back(word);
        q_acc.push_back(cyc);
        accepted = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rand_main();
    for (int i = 0; i < N; i++) m_in_data[i*DW +: DW] = 8'($urandom);
    m_in_sel = SW'($urandom);
  endtask

  initial begin
    int         sent;
    logic [7:0] w;
    rst = 1'b1;
    chk_zero = 1'b0;
    m_in_data = '0; m_in_sel = '0; m_in_valid = 1'b0; m_out_ready = 1'b1;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk_zero = 1'b1;
    tick();

    // Sweep all selects back to back
    for (int i = 0; i < N; i++) m_in_data[i*DW +: DW] = 8'hA0 + 8'(i);
    m_in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_in_sel = SW'(i);
      tick();
    end
    m_in_valid = 1'b0;
    repeat (L + 2) tick();

    // Backpressure window in the middle of an 8-word stream
    sent = 0;
    for (int t = 0; t < 24; t++) begin
      m_in_valid  = (sent < 8);
      m_out_ready = !(t >= 6 && t <= 9);
      rand_main();
      tick();
      if (accepted) sent++;
    end

    // Bubbles while the consumer is stalled
    m_out_ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      m_in_valid = (t % 2 == 0);
      rand_main();
      tick();
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    repeat (L + 4) tick();

    // Reset with three words in flight; an input offered during reset is dropped
    m_in_valid = 1'b1;
    repeat (3) begin
      rand_main();
      tick();
    end
    rst = 1'b1;
    rand_main();
    tick();
    rst = 1'b0;
    m_in_valid = 1'b0;
    chk_zero = 1'b1;
    repeat (L + 4) tick();

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      m_in_valid  = ($urandom % 4) != 0;
      m_out_ready = ($urandom % 3) != 0;
      rand_main();
      tick();
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    repeat (L + 4) tick();

    // Two registered levels: word 9 appears two cycles after acceptance
    for (int i = 0; i < N; i++) begin
      w = 8'($urandom);
      if (w == 8'h5C) w = 8'h00;
      b_in_data[i*DW +: DW] = w;
    end
    b_in_data[9*DW +: DW] = 8'h5C;
    b_in_sel   = 4'b1001;
    b_in_valid = 1'b1;
    check("b_in_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_in_valid = 1'b0;
    b_in_data  = '0;
    b_in_sel   = '0;
    check("b_valid_cycle1", 32'(b_out_valid), 32'h0);
    tick();
    check("b_valid_cycle2", 32'(b_out_valid), 32'h1);
    check("b_data_cycle2", 32'(b_out_data), 32'h5C);
    tick();
    check("b_valid_cycle3", 32'(b_out_valid), 32'h0);

    // Fully combinational tree
    for (int i = 0; i < 1000; i++) begin
      c_in_data   = 8'($urandom);
      c_in_sel    = 3'($urandom);
      c_in_valid  = 1'($urandom);
      c_out_ready = 1'($urandom);
      #1;
      check("c_out_data", 32'(c_out_data), 32'(c_in_data[c_in_sel]));
      check("c_out_valid", 32'(c_out_valid), 32'(c_in_valid));
      check("c_in_ready", 32'(c_in_ready), 32'(c_out_ready));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
